hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides every cycle whether PC, IF/ID and ID/EX advance, hold or are bubbled, for four cases: load-use hazards, taken branches/jumps, multi-cycle memory busy, and external interrupt entry.
- Sits beside the ID/EX register and drives its bubble input, the IF/ID write/flush inputs, the PC write enable and the exception-vector select.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall/flush event counters.
- EXC_VEC, 32'h80000004, exception vector output for interrupt entry.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- IDEX_MemRd  in  1  instruction in EX is a load.
- IDEX_Rd  in  5  destination register of instruction in EX.
- IFID_Rs  in  5  rs field of instruction in ID.
- IFID_Rt  in  5  rt field of instruction in ID.
- ID_UsesRt  in  1  instruction in ID reads rt as a source.
- EX_BranchTaken  in  1  branch in EX resolved taken.
- ID_Jump  in  1  j/jal/jr/jalr decoded in ID.
- mem_busy  in  1  data memory multi-cycle access in progress.
- irq  in  1  external interrupt request, level.
- kernel_mode  in  1  PC[31] of instruction in ID; interrupts masked when 1.
- PCWrite  out  1  PC register enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  load NOP into IF/ID.
- IDEXFlush  out  1  load bubble (all controls 0, RegWr=0, MemWr=0, MemRd=0) into ID/EX.
- ExcSel  out  1  PC mux selects EXC_VEC this cycle.
- irq_ack  out  1  one-cycle pulse when interrupt entry is taken.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  branch/jump/irq flush events, saturating.

Behaviour:
- Clocking: all state updates on the rising edge of clk. Outputs are combinational decode of the current state and inputs.
- Reset (synchronous, active-high): state=RUN, stall_cnt=0, flush_cnt=0. While reset=1, outputs are forced to PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, ExcSel=0, irq_ack=0.
- Load-use hazard: lu = IDEX_MemRd & IDEX_Rd!=0 & (IDEX_Rd==IFID_Rs | (ID_UsesRt & IDEX_Rd==IFID_Rt)).
- States: RUN, IRQ_WAIT, IRQ_ENTER.
- Priority in every state, highest first: mem_busy > EX_BranchTaken > IRQ_ENTER > ID_Jump > lu > normal.
- mem_busy=1 (freeze):
  - PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXFlush=0.
  - No counter changes.
  - State holds, except RUN goes to IRQ_WAIT if irq=1 & kernel_mode=0.
- EX_BranchTaken=1:
  - IFIDFlush=1, IDEXFlush=1, PCWrite=1, IFIDWrite=1.
  - flush_cnt+1.
  - If state was IRQ_ENTER, it returns to IRQ_WAIT; the interrupt is retaken after the branch.
- ID_Jump=1 (and nothing higher applies): IFIDFlush=1, flush_cnt+1, other enables 1.
- lu=1 (and nothing higher applies): PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0, stall_cnt+1. Exactly one bubble per load-use pair, because the bubble clears IDEX_MemRd the next cycle.
- Normal: all enables 1, all flushes 0.
- RUN -> IRQ_WAIT when irq=1 & kernel_mode=0.
- IRQ_WAIT:
  - Normal pipeline operation continues.
  - Goes to IRQ_ENTER on the first cycle with mem_busy=0, EX_BranchTaken=0, ID_Jump=0 and lu=0, so the interrupt is never taken in a branch/jump shadow or mid-stall.
  - Returns to RUN if irq drops before entry.
- IRQ_ENTER (exactly one cycle):
  - ExcSel=1, PCWrite=1, IFIDFlush=1, IDEXFlush=1, irq_ack=1, flush_cnt+1.
  - Next state RUN.
  - A new entry requires kernel_mode=0 again, which prevents re-entry while the handler runs.
- Counters saturate at all-ones; no wrap-around.
- Simultaneous lu and irq in RUN: the stall is taken and the state moves to IRQ_WAIT. Entry follows once lu clears.
- Reset mid-IRQ_WAIT or mid-IRQ_ENTER: returns to RUN, no irq_ack.

Test Plan:
- lw $8 in EX (IDEX_MemRd=1, IDEX_Rd=8), add using IFID_Rs=8 -> one cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1, stall_cnt 0->1; the next cycle proceeds normally.
- IDEX_Rd=0 with IDEX_MemRd=1, IFID_Rs=0 -> no stall, stall_cnt stays 0. IFID_Rt=8 with ID_UsesRt=0 -> no stall.
- EX_BranchTaken=1 with lu=1 in the same cycle -> IFIDFlush=1, IDEXFlush=1, PCWrite=1, flush_cnt+1, stall_cnt unchanged.
- irq=1, kernel_mode=0 during a taken branch -> IRQ_WAIT. The next clean cycle gives IRQ_ENTER: ExcSel=1, irq_ack pulses once, then RUN. irq held with kernel_mode=1 -> no second ack.
- mem_busy=1 for 3 cycles with irq and a jump pending -> all enables 0, counters frozen. After release, the jump flush comes first, then irq entry one cycle later.
- Force stall_cnt to 16'hFFFE, apply 3 load-use stalls -> stall_cnt holds 16'hFFFF. Reset asserted in IRQ_ENTER -> next state RUN, counters 0.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Pipeline hazard signals between the 5-stage datapath and hazard_controller.
// master = controller side (drives enables/flushes/counters), slave = datapath side.
`timescale 1ns/1ps
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic             IDEX_MemRd;
    logic [4:0]       IDEX_Rd;
    logic [4:0]       IFID_Rs;
    logic [4:0]       IFID_Rt;
    logic             ID_UsesRt;
    logic             EX_BranchTaken;
    logic             ID_Jump;
    logic             mem_busy;
    logic             irq;
    logic             kernel_mode;

    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXFlush;
    logic             ExcSel;
    logic [31:0]      exc_vec;
    logic             irq_ack;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  IDEX_MemRd, IDEX_Rd, IFID_Rs, IFID_Rt, ID_UsesRt,
               EX_BranchTaken, ID_Jump, mem_busy, irq, kernel_mode,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, ExcSel, exc_vec,
               irq_ack, stall_cnt, flush_cnt
    );

    modport slave (
        output IDEX_MemRd, IDEX_Rd, IFID_Rs, IFID_Rt, ID_UsesRt,
               EX_BranchTaken, ID_Jump, mem_busy, irq, kernel_mode,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, ExcSel, exc_vec,
               irq_ack, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing: load-use stall, branch/jump flush, memory freeze, irq entry.
// Outputs are same-cycle combinational; mem_busy freezes everything including counters.
`timescale 1ns/1ps
module hazard_controller #(
    parameter int          CNT_W   = 16,
    parameter logic [31:0] EXC_VEC = 32'h80000004
) (
    input  logic                       clk,
    input  logic                       reset,
    hazard_controller_if.master        hz
);
    typedef enum logic [1:0] {RUN, IRQ_WAIT, IRQ_ENTER} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             lu, irq_req, clean;
    logic             inc_stall, inc_flush;
    logic             pc_wr, ifid_wr, ifid_fl, idex_fl, exc_sel, ack;

    assign lu = hz.IDEX_MemRd && (hz.IDEX_Rd != 5'd0) &&
                ((hz.IDEX_Rd == hz.IFID_Rs) || (hz.ID_UsesRt && (hz.IDEX_Rd == hz.IFID_Rt)));
    assign irq_req = hz.irq && !hz.kernel_mode;
    // Entry only on a cycle with no freeze, no shadow and no stall
    assign clean   = !hz.mem_busy && !hz.EX_BranchTaken && !hz.ID_Jump && !lu;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (inc_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (inc_flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_wr     = 1'b1;
        ifid_wr   = 1'b1;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        exc_sel   = 1'b0;
        ack       = 1'b0;
        inc_stall = 1'b0;
        inc_flush = 1'b0;

        case (state)
            RUN:       if (irq_req) state_nxt = IRQ_WAIT;
            IRQ_WAIT:  if (!hz.irq) state_nxt = RUN;
                       else if (clean) state_nxt = IRQ_ENTER;
            IRQ_ENTER: state_nxt = RUN;
            default:   state_nxt = RUN;
        endcase

        if (hz.mem_busy) begin
            pc_wr     = 1'b0;
            ifid_wr   = 1'b0;
            state_nxt = (state == RUN && irq_req) ? IRQ_WAIT : state;
        end else if (hz.EX_BranchTaken) begin
            ifid_fl   = 1'b1;
            idex_fl   = 1'b1;
            inc_flush = 1'b1;
            if (state == IRQ_ENTER)
                state_nxt = IRQ_WAIT;
        end else if (state == IRQ_ENTER) begin
            exc_sel   = 1'b1;
            ifid_fl   = 1'b1;
            idex_fl   = 1'b1;
            ack       = 1'b1;
            inc_flush = 1'b1;
        end else if (hz.ID_Jump) begin
            ifid_fl   = 1'b1;
            inc_flush = 1'b1;
        end else if (lu) begin
            pc_wr     = 1'b0;
            ifid_wr   = 1'b0;
            idex_fl   = 1'b1;
            inc_stall = 1'b1;
        end

        // Reset flushes the pipe and suppresses any pending entry
        if (reset) begin
            pc_wr   = 1'b1;
            ifid_wr = 1'b1;
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
            exc_sel = 1'b0;
            ack     = 1'b0;
        end
    end

    assign hz.PCWrite   = pc_wr;
    assign hz.IFIDWrite = ifid_wr;
    assign hz.IFIDFlush = ifid_fl;
    assign hz.IDEXFlush = idex_fl;
    assign hz.ExcSel    = exc_sel;
    assign hz.exc_vec   = EXC_VEC;
    assign hz.irq_ack   = ack;
    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; ctl vector = {PCWrite,IFIDWrite,IFIDFlush,IDEXFlush,ExcSel,irq_ack}.
`timescale 1ns/1ps
module tb_hazard_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    hazard_controller_if #(.CNT_W(16)) h ();
    hazard_controller_if #(.CNT_W(2))  hs ();

    hazard_controller #(.CNT_W(16), .EXC_VEC(32'h80000004)) dut (
        .clk(clk), .reset(reset), .hz(h.master));
    hazard_controller #(.CNT_W(2), .EXC_VEC(32'h80000004)) dut_small (
        .clk(clk), .reset(reset), .hz(hs.master));

    wire [5:0] ctl  = {h.PCWrite, h.IFIDWrite, h.IFIDFlush, h.IDEXFlush, h.ExcSel, h.irq_ack};
    wire [5:0] sctl = {hs.PCWrite, hs.IFIDWrite, hs.IFIDFlush, hs.IDEXFlush, hs.ExcSel, hs.irq_ack};

    task automatic clear_inputs();
        h.IDEX_MemRd = 0; h.IDEX_Rd = 0; h.IFID_Rs = 0; h.IFID_Rt = 0; h.ID_UsesRt = 0;
        h.EX_BranchTaken = 0; h.ID_Jump = 0; h.mem_busy = 0; h.irq = 0; h.kernel_mode = 0;
        hs.IDEX_MemRd = 0; hs.IDEX_Rd = 0; hs.IFID_Rs = 0; hs.IFID_Rt = 0; hs.ID_UsesRt = 0;
        hs.EX_BranchTaken = 0; hs.ID_Jump = 0; hs.mem_busy = 0; hs.irq = 0; hs.kernel_mode = 0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #1;
        total++; if (ctl !== 6'b111100) $display("FAIL reset_ctl got=%b exp=111100", ctl); else passed++;
        tick(); tick();
        total++; if (h.stall_cnt !== 16'd0 || h.flush_cnt !== 16'd0)
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", h.stall_cnt, h.flush_cnt); else passed++;
        total++; if (h.exc_vec !== 32'h80000004) $display("FAIL exc_vec got=%h exp=80000004", h.exc_vec); else passed++;
        reset = 0;
        #1;
        total++; if (ctl !== 6'b110000) $display("FAIL idle_ctl got=%b exp=110000", ctl); else passed++;
    endtask

    task automatic test_load_use();
        h.IDEX_MemRd = 1; h.IDEX_Rd = 5'd8; h.IFID_Rs = 5'd8;
        #1;
        total++; if (ctl !== 6'b000100) $display("FAIL lu_ctl got=%b exp=000100", ctl); else passed++;
        tick();
        total++; if (h.stall_cnt !== 16'd1) $display("FAIL lu_cnt got=%0d exp=1", h.stall_cnt); else passed++;
        h.IDEX_MemRd = 0;
        #1;
        total++; if (ctl !== 6'b110000) $display("FAIL lu_after_ctl got=%b exp=110000", ctl); else passed++;
        tick();
        total++; if (h.stall_cnt !== 16'd1) $display("FAIL lu_after_cnt got=%0d exp=1", h.stall_cnt); else passed++;
    endtask

    task automatic test_no_stall();
        h.IDEX_MemRd = 1; h.IDEX_Rd = 5'd0; h.IFID_Rs = 5'd0;
        #1;
        total++; if (ctl !== 6'b110000) $display("FAIL rd0_ctl got=%b exp=110000", ctl); else passed++;
        tick();
        h.IDEX_Rd = 5'd8; h.IFID_Rs = 5'd3; h.IFID_Rt = 5'd8; h.ID_UsesRt = 0;
        #1;
        total++; if (ctl !== 6'b110000) $display("FAIL rt_unused_ctl got=%b exp=110000", ctl); else passed++;
        tick();
        total++; if (h.stall_cnt !== 16'd1) $display("FAIL no_stall_cnt got=%0d exp=1", h.stall_cnt); else passed++;
        h.ID_UsesRt = 1;
        #1;
        total++; if (ctl !== 6'b000100) $display("FAIL rt_used_ctl got=%b exp=000100", ctl); else passed++;
        tick();
        total++; if (h.stall_cnt !== 16'd2) $display("FAIL rt_used_cnt got=%0d exp=2", h.stall_cnt); else passed++;
        clear_inputs();
    endtask

    task automatic test_branch_over_lu();
        h.IDEX_MemRd = 1; h.IDEX_Rd = 5'd8; h.IFID_Rs = 5'd8; h.EX_BranchTaken = 1;
        #1;
        total++; if (ctl !== 6'b111100) $display("FAIL br_lu_ctl got=%b exp=111100", ctl); else passed++;
        tick();
        total++; if (h.flush_cnt !== 16'd1 || h.stall_cnt !== 16'd2)
            $display("FAIL br_lu_cnt got=%0d/%0d exp=1/2", h.flush_cnt, h.stall_cnt); else passed++;
        clear_inputs();
    endtask

    task automatic test_irq_after_branch();
        h.irq = 1; h.EX_BranchTaken = 1;
        #1;
        total++; if (ctl !== 6'b111100) $display("FAIL irq_br_ctl got=%b exp=111100", ctl); else passed++;
        tick();
        h.EX_BranchTaken = 0;
        #1;
        total++; if (ctl !== 6'b110000) $display("FAIL irq_wait_ctl got=%b exp=110000", ctl); else passed++;
        tick();
        h.kernel_mode = 1;
        #1;
        total++; if (ctl !== 6'b111111) $display("FAIL irq_enter_ctl got=%b exp=111111", ctl); else passed++;
        tick();
        total++; if (h.flush_cnt !== 16'd3) $display("FAIL irq_flush_cnt got=%0d exp=3", h.flush_cnt); else passed++;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctl !== 6'b110000) $display("FAIL irq_masked_%0d got=%b exp=110000", i, ctl); else passed++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_mem_busy();
        h.mem_busy = 1; h.irq = 1; h.ID_Jump = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctl !== 6'b000000) $display("FAIL busy_ctl_%0d got=%b exp=000000", i, ctl); else passed++;
            tick();
        end
        total++; if (h.flush_cnt !== 16'd3 || h.stall_cnt !== 16'd2)
            $display("FAIL busy_cnt got=%0d/%0d exp=3/2", h.flush_cnt, h.stall_cnt); else passed++;
        h.mem_busy = 0;
        #1;
        total++; if (ctl !== 6'b111000) $display("FAIL busy_jump_ctl got=%b exp=111000", ctl); else passed++;
        tick();
        h.ID_Jump = 0;
        #1;
        total++; if (ctl !== 6'b110000) $display("FAIL busy_wait_ctl got=%b exp=110000", ctl); else passed++;
        tick();
        total++; if (ctl !== 6'b111111) $display("FAIL busy_enter_ctl got=%b exp=111111", ctl); else passed++;
        h.irq = 0;
        tick();
        total++; if (h.flush_cnt !== 16'd5) $display("FAIL busy_flush_cnt got=%0d exp=5", h.flush_cnt); else passed++;
        clear_inputs();
    endtask

    task automatic test_lu_with_irq();
        h.IDEX_MemRd = 1; h.IDEX_Rd = 5'd9; h.IFID_Rt = 5'd9; h.ID_UsesRt = 1; h.irq = 1;
        #1;
        total++; if (ctl !== 6'b000100) $display("FAIL lu_irq_ctl got=%b exp=000100", ctl); else passed++;
        tick();
        h.IDEX_MemRd = 0;
        #1;
        total++; if (ctl !== 6'b110000) $display("FAIL lu_irq_wait got=%b exp=110000", ctl); else passed++;
        tick();
        total++; if (ctl !== 6'b111111) $display("FAIL lu_irq_enter got=%b exp=111111", ctl); else passed++;
        h.irq = 0;
        tick();
        total++; if (h.stall_cnt !== 16'd3 || h.flush_cnt !== 16'd6)
            $display("FAIL lu_irq_cnt got=%0d/%0d exp=3/6", h.stall_cnt, h.flush_cnt); else passed++;
        clear_inputs();
    endtask

    task automatic test_reset_in_enter();
        h.irq = 1;
        tick();
        tick();
        reset = 1;
        #1;
        total++; if (ctl !== 6'b111100) $display("FAIL rst_enter_ctl got=%b exp=111100", ctl); else passed++;
        tick();
        reset = 0; h.irq = 0;
        #1;
        total++; if (ctl !== 6'b110000) $display("FAIL rst_enter_after got=%b exp=110000", ctl); else passed++;
        total++; if (h.stall_cnt !== 16'd0 || h.flush_cnt !== 16'd0)
            $display("FAIL rst_enter_cnt got=%0d/%0d exp=0/0", h.stall_cnt, h.flush_cnt); else passed++;
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        hs.IDEX_MemRd = 1; hs.IDEX_Rd = 5'd4; hs.IFID_Rs = 5'd4;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (sctl !== 6'b000100) $display("FAIL sat_ctl_%0d got=%b exp=000100", i, sctl); else passed++;
            tick();
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            total++; if (hs.stall_cnt !== exp_cnt)
                $display("FAIL sat_stall_%0d got=%0d exp=%0d", i, hs.stall_cnt, exp_cnt); else passed++;
        end
        hs.IDEX_MemRd = 0; hs.EX_BranchTaken = 1;
        for (int i = 0; i < 4; i++) tick();
        total++; if (hs.flush_cnt !== 2'd3) $display("FAIL sat_flush got=%0d exp=3", hs.flush_cnt); else passed++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_over_lu();
        test_irq_after_branch();
        test_mem_busy();
        test_lu_with_irq();
        test_saturation();
        test_reset_in_enter();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
